// File: rtl/icache_miss_controller_if.sv
// Lookup, memory and array-fill signals of the icache miss controller.
// master = controller side, slave = surrounding pipeline/memory/arrays.
interface icache_miss_controller_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int WORD_WIDTH = 32,
   parameter int LINE_WORDS = 4
);
   localparam int OFS = $clog2(LINE_WORDS);

   logic                  i_halt;
   logic                  i_valid;
   logic [ADDR_WIDTH-1:0] i_addr;
   logic                  i_cache_hit;
   logic                  o_user_if_ready;
   logic                  o_miss_state;
   logic                  o_mem_req_valid;
   logic [ADDR_WIDTH-1:0] o_mem_req_addr;
   logic                  i_mem_req_ready;
   logic                  i_mem_resp_valid;
   logic [WORD_WIDTH-1:0] i_mem_resp_data;
   logic                  o_mem_resp_ready;
   logic                  o_fill_we;
   logic [OFS-1:0]        o_fill_word_idx;
   logic [WORD_WIDTH-1:0] o_fill_data;
   logic                  o_array_update_start;
   logic                  i_array_update_done;
   logic                  o_miss_data_valid;
   logic [WORD_WIDTH-1:0] o_miss_data;
   logic                  o_error;

   modport master (
      input  i_halt, i_valid, i_addr, i_cache_hit,
      input  i_mem_req_ready, i_mem_resp_valid, i_mem_resp_data, i_array_update_done,
      output o_user_if_ready, o_miss_state, o_mem_req_valid, o_mem_req_addr,
      output o_mem_resp_ready, o_fill_we, o_fill_word_idx, o_fill_data,
      output o_array_update_start, o_miss_data_valid, o_miss_data, o_error
   );

   modport slave (
      output i_halt, i_valid, i_addr, i_cache_hit,
      output i_mem_req_ready, i_mem_resp_valid, i_mem_resp_data, i_array_update_done,
      input  o_user_if_ready, o_miss_state, o_mem_req_valid, o_mem_req_addr,
      input  o_mem_resp_ready, o_fill_we, o_fill_word_idx, o_fill_data,
      input  o_array_update_start, o_miss_data_valid, o_miss_data, o_error
   );
endinterface

// File: rtl/icache_miss_controller.sv
// Instruction cache miss handler: line request, in-order beat fill with early
// restart of the missed word, bounded timeout retries, then tag/valid update.
module icache_miss_controller #(
   parameter int ADDR_WIDTH     = 32,
   parameter int WORD_WIDTH     = 32,
   parameter int LINE_WORDS     = 4,
   parameter int TIMEOUT_CYCLES = 64,
   parameter int MAX_RETRIES    = 2
) (
   input logic clk,
   input logic arst_n,
   icache_miss_controller_if.master bus
);
   localparam int OFS = $clog2(LINE_WORDS);
   localparam int TW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int RW  = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
   localparam logic [TW-1:0]  TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [RW-1:0]  RETRY_MAX = RW'(MAX_RETRIES);
   localparam logic [OFS:0]   LAST_BEAT = (OFS + 1)'(LINE_WORDS - 1);

   typedef enum logic [2:0] {S_IDLE, S_REQ, S_FILL, S_UPDATE, S_ERR} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [OFS:0]          beat_q, beat_d;
   logic [TW-1:0]         timer_q, timer_d;
   logic [RW-1:0]         retry_q, retry_d;
   logic                  dlv_q, dlv_d;
   logic [WORD_WIDTH-1:0] mdata_q, mdata_d;
   logic                  mdv_q, mdv_d;
   logic                  err_q, err_d;
   logic                  aus_q, aus_d;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      beat_d  = beat_q;
      timer_d = timer_q;
      retry_d = retry_q;
      dlv_d   = dlv_q;
      mdata_d = mdata_q;
      mdv_d   = 1'b0;
      err_d   = 1'b0;
      aus_d   = 1'b0;
      if (bus.i_halt) begin
         // frozen: pending response/update pulses survive until release
         mdv_d = mdv_q;
         err_d = err_q;
         aus_d = aus_q;
      end else begin
         case (state_q)
            S_IDLE: if (bus.i_valid && !bus.i_cache_hit) begin
               state_d = S_REQ;
               addr_d  = bus.i_addr;
               retry_d = '0;
               dlv_d   = 1'b0;
            end
            S_REQ: if (bus.i_mem_req_ready) begin
               state_d = S_FILL;
               beat_d  = '0;
               timer_d = '0;
            end
            S_FILL: begin
               if (bus.i_mem_resp_valid) begin
                  beat_d  = beat_q + 1'b1;
                  timer_d = '0;
                  if (beat_q[OFS-1:0] == addr_q[OFS-1:0] && !dlv_q) begin
                     mdata_d = bus.i_mem_resp_data;
                     dlv_d   = 1'b1;
                     mdv_d   = 1'b1;
                  end
                  if (beat_q == LAST_BEAT) begin
                     state_d = S_UPDATE;
                     aus_d   = 1'b1;
                  end
               end else if (TIMEOUT_CYCLES != 0) begin
                  if (timer_q == TMO_LAST) begin
                     if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + 1'b1;
                        state_d = S_REQ;
                        beat_d  = '0;
                        timer_d = '0;
                     end else begin
                        state_d = S_ERR;
                        mdv_d   = 1'b1;
                        err_d   = 1'b1;
                     end
                  end else begin
                     timer_d = timer_q + 1'b1;
                  end
               end
            end
            S_UPDATE: if (bus.i_array_update_done) state_d = S_IDLE;
            S_ERR:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!arst_n) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         beat_q  <= '0;
         timer_q <= '0;
         retry_q <= '0;
         dlv_q   <= 1'b0;
         mdata_q <= '0;
         mdv_q   <= 1'b0;
         err_q   <= 1'b0;
         aus_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         beat_q  <= beat_d;
         timer_q <= timer_d;
         retry_q <= retry_d;
         dlv_q   <= dlv_d;
         mdata_q <= mdata_d;
         mdv_q   <= mdv_d;
         err_q   <= err_d;
         aus_q   <= aus_d;
      end
   end

   assign bus.o_user_if_ready      = (state_q == S_IDLE) && !bus.i_halt;
   assign bus.o_miss_state         = (state_q != S_IDLE);
   assign bus.o_mem_req_valid      = (state_q == S_REQ) && !bus.i_halt;
   assign bus.o_mem_req_addr       = (state_q == S_REQ) ?
                                     {addr_q[ADDR_WIDTH-1:OFS], {OFS{1'b0}}} : '0;
   assign bus.o_mem_resp_ready     = (state_q == S_FILL) && !bus.i_halt;
   assign bus.o_fill_we            = bus.o_mem_resp_ready && bus.i_mem_resp_valid;
   assign bus.o_fill_word_idx      = bus.o_fill_we ? beat_q[OFS-1:0] : '0;
   assign bus.o_fill_data          = bus.o_fill_we ? bus.i_mem_resp_data : '0;
   assign bus.o_array_update_start = aus_q && !bus.i_halt;
   assign bus.o_miss_data_valid    = mdv_q && !bus.i_halt;
   assign bus.o_miss_data          = mdata_q;
   assign bus.o_error              = err_q;
endmodule

// File: tb/tb_icache_miss_controller.sv
// Directed vector table plus hand sequences for timeout/retry, early-restart
// uniqueness and mid-fill reset of the icache miss controller.
module tb_icache_miss_controller;
   logic clk = 1'b0;
   logic arst_n;
   always #5 clk = ~clk;

   icache_miss_controller_if #(.ADDR_WIDTH(32), .WORD_WIDTH(32), .LINE_WORDS(4)) bus ();

   icache_miss_controller #(
      .ADDR_WIDTH(32), .WORD_WIDTH(32), .LINE_WORDS(4),
      .TIMEOUT_CYCLES(8), .MAX_RETRIES(1)
   ) dut (
      .clk(clk), .arst_n(arst_n), .bus(bus)
   );

   int total = 0;
   int fails = 0;
   int mdv_cnt = 0;
   int aus_cnt = 0;

   always @(negedge clk) begin
      if (bus.o_miss_data_valid)    mdv_cnt++;
      if (bus.o_array_update_start) aus_cnt++;
   end

   typedef struct {
      logic halt, valid, hit, rq, rv, dn;
      logic [31:0] addr, rd;
      logic [105:0] exp;
   } vec_t;

   function automatic vec_t mk(
      input logic h, v, hit, input logic [31:0] a, input logic rq, rv,
      input logic [31:0] rd, input logic dn,
      input logic rdy, mst, rqv, input logic [31:0] rqa, input logic rsr, we,
      input logic [1:0] idx, input logic [31:0] fd, input logic aus, mdv, err,
      input logic [31:0] md);
      vec_t t;
      t.halt = h; t.valid = v; t.hit = hit; t.addr = a; t.rq = rq; t.rv = rv;
      t.rd = rd; t.dn = dn;
      t.exp = {rdy, mst, rqv, rqa, rsr, we, idx, fd, aus, mdv, err, md};
      return t;
   endfunction

   function automatic logic [105:0] act_out();
      return {bus.o_user_if_ready, bus.o_miss_state, bus.o_mem_req_valid,
              bus.o_mem_req_addr, bus.o_mem_resp_ready, bus.o_fill_we,
              bus.o_fill_word_idx, bus.o_fill_data, bus.o_array_update_start,
              bus.o_miss_data_valid, bus.o_error, bus.o_miss_data};
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic h, v, hit, input logic [31:0] a,
                        input logic rq, rv, input logic [31:0] rd, input logic dn);
      bus.i_halt = h; bus.i_valid = v; bus.i_cache_hit = hit; bus.i_addr = a;
      bus.i_mem_req_ready = rq; bus.i_mem_resp_valid = rv;
      bus.i_mem_resp_data = rd; bus.i_array_update_done = dn;
   endtask

   task automatic idle();
      drive(0, 0, 0, 32'h0, 0, 0, 32'h0, 0);
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   vec_t vt[$];

   initial begin
      int a0, m0;
      logic ok;
      // expected: rdy mst rqv rqa rsr we idx fd aus mdv err md
      vt.push_back(mk(0,0,0,32'h0,  0,0,32'h0,0, 1,0,0,32'h0,  0,0,2'd0,32'h0, 0,0,0,32'h0));
      vt.push_back(mk(0,1,1,32'h200,0,0,32'h0,0, 1,0,0,32'h0,  0,0,2'd0,32'h0, 0,0,0,32'h0));
      vt.push_back(mk(0,1,0,32'h106,0,0,32'h0,0, 1,0,0,32'h0,  0,0,2'd0,32'h0, 0,0,0,32'h0));
      vt.push_back(mk(0,0,0,32'h0,  1,0,32'h0,0, 0,1,1,32'h104,0,0,2'd0,32'h0, 0,0,0,32'h0));
      vt.push_back(mk(0,0,0,32'h0,  0,1,32'hA0,0, 0,1,0,32'h0, 1,1,2'd0,32'hA0, 0,0,0,32'h0));
      vt.push_back(mk(0,0,0,32'h0,  0,1,32'hA1,0, 0,1,0,32'h0, 1,1,2'd1,32'hA1, 0,0,0,32'h0));
      vt.push_back(mk(0,0,0,32'h0,  0,1,32'hA2,0, 0,1,0,32'h0, 1,1,2'd2,32'hA2, 0,0,0,32'h0));
      vt.push_back(mk(0,0,0,32'h0,  0,1,32'hA3,0, 0,1,0,32'h0, 1,1,2'd3,32'hA3, 0,1,0,32'hA2));
      vt.push_back(mk(0,0,0,32'h0,  0,0,32'h0,0,  0,1,0,32'h0, 0,0,2'd0,32'h0,  1,0,0,32'hA2));
      vt.push_back(mk(0,0,0,32'h0,  0,0,32'h0,1,  0,1,0,32'h0, 0,0,2'd0,32'h0,  0,0,0,32'hA2));
      vt.push_back(mk(0,0,0,32'h0,  0,0,32'h0,0,  1,0,0,32'h0, 0,0,2'd0,32'h0,  0,0,0,32'hA2));
      // halt mid-fill, then a halted UPDATE entry whose pulses arrive on release
      vt.push_back(mk(0,1,0,32'h13, 0,0,32'h0,0,  1,0,0,32'h0, 0,0,2'd0,32'h0,  0,0,0,32'hA2));
      vt.push_back(mk(0,0,0,32'h0,  1,0,32'h0,0,  0,1,1,32'h10,0,0,2'd0,32'h0,  0,0,0,32'hA2));
      vt.push_back(mk(0,0,0,32'h0,  0,1,32'hB0,0, 0,1,0,32'h0, 1,1,2'd0,32'hB0, 0,0,0,32'hA2));
      for (int i = 0; i < 3; i++)
         vt.push_back(mk(1,0,0,32'h0,0,1,32'hB1,0, 0,1,0,32'h0, 0,0,2'd0,32'h0, 0,0,0,32'hA2));
      vt.push_back(mk(0,0,0,32'h0,  0,1,32'hB1,0, 0,1,0,32'h0, 1,1,2'd1,32'hB1, 0,0,0,32'hA2));
      vt.push_back(mk(0,0,0,32'h0,  0,1,32'hB2,0, 0,1,0,32'h0, 1,1,2'd2,32'hB2, 0,0,0,32'hA2));
      vt.push_back(mk(0,0,0,32'h0,  0,1,32'hB3,0, 0,1,0,32'h0, 1,1,2'd3,32'hB3, 0,0,0,32'hA2));
      vt.push_back(mk(1,0,0,32'h0,  0,0,32'h0,0,  0,1,0,32'h0, 0,0,2'd0,32'h0,  0,0,0,32'hB3));
      vt.push_back(mk(0,0,0,32'h0,  0,0,32'h0,1,  0,1,0,32'h0, 0,0,2'd0,32'h0,  1,1,0,32'hB3));
      vt.push_back(mk(0,0,0,32'h0,  0,0,32'h0,0,  1,0,0,32'h0, 0,0,2'd0,32'h0,  0,0,0,32'hB3));
      vt.push_back(mk(1,0,0,32'h0,  0,0,32'h0,0,  0,0,0,32'h0, 0,0,2'd0,32'h0,  0,0,0,32'hB3));

      idle();
      arst_n = 1'b0;
      nxt(); nxt();
      arst_n = 1'b1;

      foreach (vt[i]) begin
         drive(vt[i].halt, vt[i].valid, vt[i].hit, vt[i].addr,
               vt[i].rq, vt[i].rv, vt[i].rd, vt[i].dn);
         #1;
         chk($sformatf("vec%0d", i), {22'h0, act_out()}, {22'h0, vt[i].exp});
         nxt();
      end

      // timeout -> one retry -> error response without array update
      a0 = aus_cnt;
      drive(0, 1, 0, 32'h21, 0, 0, 32'h0, 0); nxt();
      idle(); bus.i_mem_req_ready = 1'b1; #1;
      chk("tmo_req", {bus.o_mem_req_valid, bus.o_mem_req_addr}, {1'b1, 32'h20});
      nxt(); idle();
      ok = 1'b1;
      for (int i = 0; i < 8; i++) begin #1; ok &= bus.o_mem_resp_ready; nxt(); end
      chk("tmo_fill_wait", ok, 1'b1);
      #1; chk("tmo_retry_req", {bus.o_mem_req_valid, bus.o_mem_req_addr}, {1'b1, 32'h20});
      bus.i_mem_req_ready = 1'b1; nxt(); idle();
      for (int i = 0; i < 8; i++) nxt();
      #1; chk("tmo_err", {bus.o_miss_data_valid, bus.o_error, bus.o_miss_state}, 3'b111);
      nxt();
      #1; chk("tmo_idle", {bus.o_miss_data_valid, bus.o_user_if_ready, bus.o_miss_state}, 3'b010);
      chk("tmo_no_update", aus_cnt - a0, 0);
      nxt();

      // missed word at offset 0 delivered, timeout, retried fill -> single response
      a0 = aus_cnt; m0 = mdv_cnt;
      drive(0, 1, 0, 32'h40, 0, 0, 32'h0, 0); nxt();
      idle(); bus.i_mem_req_ready = 1'b1; nxt();
      idle(); bus.i_mem_resp_valid = 1'b1; bus.i_mem_resp_data = 32'hD0; nxt();
      idle();
      for (int i = 0; i < 8; i++) nxt();
      #1; chk("dlv_retry_req", {bus.o_mem_req_valid, bus.o_miss_data}, {1'b1, 32'hD0});
      bus.i_mem_req_ready = 1'b1; nxt(); idle();
      for (int i = 0; i < 4; i++) begin
         bus.i_mem_resp_valid = 1'b1; bus.i_mem_resp_data = 32'hE0 + i; nxt();
      end
      idle(); #1;
      chk("dlv_update", {bus.o_array_update_start, bus.o_miss_data}, {1'b1, 32'hD0});
      bus.i_array_update_done = 1'b1; nxt(); idle(); #1;
      chk("dlv_one_resp", mdv_cnt - m0, 1);
      chk("dlv_one_update", aus_cnt - a0, 1);
      nxt();

      // reset during beat 1 abandons the miss
      drive(0, 1, 0, 32'h80, 0, 0, 32'h0, 0); nxt();
      idle(); bus.i_mem_req_ready = 1'b1; nxt();
      idle(); bus.i_mem_resp_valid = 1'b1; bus.i_mem_resp_data = 32'hF0; nxt();
      bus.i_mem_resp_data = 32'hF1; arst_n = 1'b0; nxt();
      arst_n = 1'b1; idle(); #1;
      chk("rst_outputs", {bus.o_user_if_ready, bus.o_miss_state, bus.o_mem_req_valid,
          bus.o_fill_we, bus.o_miss_data_valid, bus.o_array_update_start, bus.o_error,
          bus.o_miss_data}, {7'b1000000, 32'h0});
      bus.i_valid = 1'b1; bus.i_addr = 32'hC5; nxt();
      idle(); #1;
      chk("rst_new_miss", {bus.o_mem_req_valid, bus.o_mem_req_addr}, {1'b1, 32'hC4});

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end
endmodule

// File: doc/icache_miss_controller.md
# icache_miss_controller

Parametrised miss-handling controller for the instruction cache, successor to the three-state idle/mem-request/array-update controller. It accepts a miss from the lookup stage and issues one line-aligned memory request. It then receives a multi-beat line fill, writing each beat into the data array, and forwards the missed word early as soon as its beat arrives. Response timeouts are retried a bounded number of times, then an error response is returned; completion is handed to the tag/valid array update logic. It sits between the lookup pipeline, the memory interface and the cache arrays.

## Interface
- ADDR_WIDTH, 32, word address width (word-addressed; no byte offset).
- WORD_WIDTH, 32, instruction word width.
- LINE_WORDS, 4, words per line; power of two, ≥2; OFS = log2(LINE_WORDS).
- TIMEOUT_CYCLES, 64, idle cycles in FILL before timeout; 0 disables the timeout.
- MAX_RETRIES, 2, re-requests allowed after timeouts before error.

Ports:
- clk  in  1  clock, all state on rising edge.
- arst_n  in  1  reset, synchronous, active-low.
- i_halt  in  1  freeze: state/counters hold; all handshake outputs forced 0.
- i_valid  in  1  lookup request valid.
- i_addr  in  ADDR_WIDTH  lookup word address.
- i_cache_hit  in  1  lookup hit.
- o_user_if_ready  out  1  controller can accept a miss.
- o_miss_state  out  1  controller not IDLE.
- o_mem_req_valid  out  1  memory request valid.
- o_mem_req_addr  out  ADDR_WIDTH  line address (low OFS bits zero).
- i_mem_req_ready  in  1  memory accepts request.
- i_mem_resp_valid  in  1  fill beat valid.
- i_mem_resp_data  in  WORD_WIDTH  fill beat data.
- o_mem_resp_ready  out  1  controller accepts beat.
- o_fill_we  out  1  data-array word write strobe.
- o_fill_word_idx  out  OFS  word index within the line.
- o_fill_data  out  WORD_WIDTH  word to write.
- o_array_update_start  out  1  one-cycle pulse: start tag/valid update.
- i_array_update_done  in  1  tag/valid update complete.
- o_miss_data_valid  out  1  one-cycle miss response.
- o_miss_data  out  WORD_WIDTH  missed word.
- o_error  out  1  qualifies o_miss_data_valid: fill failed.

## Operation
- States: IDLE, REQ, FILL, UPDATE, ERR. Registers: r_state, r_addr, beat counter (OFS+1 bits), timer, retry counter, r_delivered flag, r_miss_data.
- o_user_if_ready = (state==IDLE) & ~i_halt. o_miss_state = state!=IDLE.
- IDLE: i_valid & ~i_cache_hit & ready → capture r_addr=i_addr, clear retries and r_delivered, go to REQ. Hits are ignored.
- REQ: o_mem_req_valid=1, o_mem_req_addr = r_addr with low OFS bits zeroed. On i_mem_req_ready → FILL, beat=0, timer=0.
- FILL: o_mem_resp_ready=1. Beats arrive in order, word 0 first.
  - Each accepted beat asserts o_fill_we the same cycle, with o_fill_word_idx=beat and o_fill_data=i_mem_resp_data. The beat counter then increments and the timer clears.
  - If beat == r_addr[OFS-1:0] and ~r_delivered: latch the data and set r_delivered. o_miss_data_valid pulses the next cycle (early restart).
  - Accepting beat LINE_WORDS-1 → UPDATE.
  - No beat: timer increments. When timer reaches TIMEOUT_CYCLES-1: if retries<MAX_RETRIES, increment retries and go to REQ (beat reset; r_delivered kept, so no duplicate response); else go to ERR.
  - A beat and a timeout in the same cycle: the beat wins.
- UPDATE: o_array_update_start pulses in the first UPDATE cycle only. On i_array_update_done → IDLE.
- ERR: one cycle with o_miss_data_valid=1 and o_error=1, then IDLE. No array update, so the line stays invalid. o_miss_data is don't-care.
- Halt: r_state, counters and timer hold. o_mem_req_valid, o_mem_resp_ready, o_fill_we, o_user_if_ready, o_miss_data_valid and o_array_update_start are forced 0. A pending pulse is delivered after halt deasserts.

## Timing
- Reset (arst_n=0 at an edge): state IDLE, all counters/flags 0. Every output is 0 except o_user_if_ready, which is 1 when i_halt=0. Reset mid-fill abandons the miss with no response.
- o_fill_we, o_mem_req_valid, o_mem_resp_ready and the ready signals are combinational from state and inputs. o_miss_data_valid, o_error and o_array_update_start are registered.
- Minimum miss latency (ready and beats back-to-back, missed word at offset k): the miss is accepted at cycle 0, REQ is at 1, FILL beats run at 2..LINE_WORDS+1, and the response appears at cycle k+3. UPDATE starts at LINE_WORDS+2. The earliest next miss is accepted the cycle after done.
- Reset does not depend on i_halt.

## Test plan
- LINE_WORDS=4. Miss at addr 0x106, with ready and beats immediate → req addr 0x104. Four fill writes at idx 0..3. o_miss_data_valid with beat-2 data at cycle 5. o_array_update_start at cycle 6. IDLE after done.
- Hit (i_valid=1, i_cache_hit=1) → no state change; o_user_if_ready stays 1.
- TIMEOUT_CYCLES=8, MAX_RETRIES=1, no beats → retry REQ after 8 idle FILL cycles. After a second timeout, ERR: o_miss_data_valid=1 and o_error=1 for one cycle; no array update.
- Missed word delivered (offset 0), then timeout and retry completes → exactly one o_miss_data_valid, then a normal UPDATE.
- i_halt=1 for 3 cycles mid-FILL with i_mem_resp_valid=1 → no fill writes and state holds. Fill resumes with the correct idx after release.
- arst_n=0 during FILL beat 1 → next cycle IDLE, outputs at reset values, and a new miss is accepted.
